// File: rtl/lcd_bus_sched_pkg.sv
// rtl/lcd_bus_sched_pkg.sv - shared LCD command constants and scheduler state encoding
package lcd_bus_sched_pkg;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;

  typedef enum logic [2:0] {
    INIT_SETUP,
    INIT_STROBE,
    IDLE,
    SETUP,
    STROBE,
    WAIT
  } lcd_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = FUNC_SET;
      2'd1:    init_cmd = DISP_ON;
      2'd2:    init_cmd = ENTRY_MODE;
      default: init_cmd = CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// rtl/lcd_rr_arb.sv - two-way round-robin grant; last=1 means requester 1 won most recently
module lcd_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// rtl/lcd_bus_sched.sv - LCD bus scheduler: power-on init, then round-robin byte writes from two requesters
module lcd_bus_sched
  import lcd_bus_sched_pkg::*;
#(
  parameter int CLR_WAIT = 2,
  parameter bit INIT_EN  = 1'b1
) (
  input  logic       clk_LCD,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  output logic       ack0,
  output logic       ack1,
  output logic       en,
  output logic       RS,
  output logic       RW,
  output logic [7:0] data,
  output logic       busy,
  output logic       init_done
);

  lcd_state_e state;
  logic [1:0] init_idx;
  logic [7:0] wait_cnt;
  logic [1:0] gnt;
  logic [1:0] gnt_q;
  logic       last_gnt;

  assign RW = 1'b0;

  lcd_rr_arb u_arb (
    .req  ({req1, req0}),
    .last (last_gnt),
    .gnt  (gnt)
  );

  // Outputs are registered while leaving a state, so they describe the state just executed.
  always_ff @(posedge clk_LCD or posedge rst) begin
    if (rst) begin
      state     <= INIT_EN ? INIT_SETUP : IDLE;
      init_idx  <= 2'd0;
      wait_cnt  <= 8'd0;
      gnt_q     <= 2'b00;
      last_gnt  <= 1'b1;
      en        <= 1'b0;
      RS        <= 1'b0;
      data      <= 8'h00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      en   <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= 1'b1;
      case (state)
        INIT_SETUP: begin
          data  <= init_cmd(init_idx);
          RS    <= 1'b0;
          state <= INIT_STROBE;
        end
        INIT_STROBE: begin
          en       <= 1'b1;
          init_idx <= init_idx + 2'd1;
          if (init_idx == 2'd3) state <= (CLR_WAIT == 0) ? IDLE : WAIT;
          else                  state <= INIT_SETUP;
        end
        IDLE: begin
          busy      <= 1'b0;
          init_done <= 1'b1;
          if (|gnt) begin
            gnt_q    <= gnt;
            last_gnt <= gnt[1];
            RS       <= gnt[1] ? rs1 : rs0;
            data     <= gnt[1] ? byte1 : byte0;
            state    <= SETUP;
          end
        end
        SETUP: state <= STROBE;
        STROBE: begin
          en   <= 1'b1;
          ack0 <= gnt_q[0];
          ack1 <= gnt_q[1];
          if (!RS && (data == CLEAR || data == HOME) && CLR_WAIT != 0) state <= WAIT;
          else                                                         state <= IDLE;
        end
        WAIT: begin
          if (wait_cnt == 8'(CLR_WAIT - 1)) begin
            wait_cnt <= 8'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// tb/tb_lcd_bus_sched.sv - directed bench for lcd_bus_sched (init, single write, clear wait, reset abort, round-robin)
module tb_lcd_bus_sched;

  logic       clk_LCD = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
  logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
  logic       ack0, ack1, en, RS, RW, busy, init_done;
  logic [7:0] data;
  logic       d2_ack0, d2_ack1, d2_en, d2_rs, d2_rw, d2_busy, d2_init_done;
  logic [7:0] d2_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_LCD = ~clk_LCD;

  lcd_bus_sched #(.CLR_WAIT(2), .INIT_EN(1'b1)) dut (
    .clk_LCD(clk_LCD), .rst(rst),
    .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1), .byte0(byte0), .byte1(byte1),
    .ack0(ack0), .ack1(ack1), .en(en), .RS(RS), .RW(RW), .data(data),
    .busy(busy), .init_done(init_done)
  );

  lcd_bus_sched #(.CLR_WAIT(2), .INIT_EN(1'b0)) dut_noinit (
    .clk_LCD(clk_LCD), .rst(rst),
    .req0(1'b0), .req1(1'b0), .rs0(1'b0), .rs1(1'b0), .byte0(8'h00), .byte1(8'h00),
    .ack0(d2_ack0), .ack1(d2_ack1), .en(d2_en), .RS(d2_rs), .RW(d2_rw), .data(d2_data),
    .busy(d2_busy), .init_done(d2_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_LCD);
  endtask

  // Cycle c counts rising edges after reset release; CLR_WAIT=2.
  task automatic run_init();
    logic [7:0] exp_data [1:11];
    exp_data = '{8'h38, 8'h38, 8'h0C, 8'h0C, 8'h06, 8'h06, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    for (int c = 1; c <= 11; c++) begin
      step();
      chk($sformatf("init_data_c%0d", c), data, exp_data[c]);
      chk($sformatf("init_en_c%0d", c), en, (c % 2 == 0 && c <= 8));
      chk($sformatf("init_rs_c%0d", c), RS, 0);
      chk($sformatf("init_ack_c%0d", c), {ack1, ack0}, 0);
      chk($sformatf("init_busy_c%0d", c), busy, (c < 11));
      chk($sformatf("init_done_c%0d", c), init_done, (c >= 11));
      chk($sformatf("noinit_en_c%0d", c), d2_en, 0);
      if (c == 1) begin
        chk("noinit_done", d2_init_done, 1);
        chk("noinit_busy", d2_busy, 0);
      end
    end
  endtask

  initial begin
    step(); step();
    chk("rst_en", en, 0);
    chk("rst_rs", RS, 0);
    chk("rst_rw", RW, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("noinit_rst_busy", d2_busy, 1);
    chk("noinit_rst_done", d2_init_done, 0);
    rst = 1'b0;
    run_init();

    // single data write from requester 0
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'h53;
    step();
    chk("w0_idle_ack", ack0, 0);
    step();
    chk("w0_setup_en", en, 0);
    chk("w0_setup_data", data, 8'h53);
    chk("w0_setup_ack", ack0, 0);
    step();
    chk("w0_strobe_en", en, 1);
    chk("w0_strobe_data", data, 8'h53);
    chk("w0_strobe_rs", RS, 1);
    chk("w0_strobe_rw", RW, 0);
    chk("w0_strobe_ack0", ack0, 1);
    chk("w0_strobe_ack1", ack1, 0);
    req0 = 1'b0;
    step();
    chk("w0_idle_busy", busy, 0);
    chk("w0_idle_ack0", ack0, 0);
    chk("w0_idle_data_hold", data, 8'h53);

    // clear command from requester 1, then req0 raised during WAIT
    req1 = 1'b1; rs1 = 1'b0; byte1 = 8'h01;
    step(); step();
    chk("clr_setup_ack", {ack1, ack0}, 0);
    step();
    chk("clr_strobe_ack1", ack1, 1);
    chk("clr_strobe_ack0", ack0, 0);
    chk("clr_strobe_data", data, 8'h01);
    chk("clr_strobe_rs", RS, 0);
    req1 = 1'b0;
    step();
    chk("clr_wait1_busy", busy, 1);
    chk("clr_wait1_en", en, 0);
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'h41;
    step();
    chk("clr_wait2_busy", busy, 1);
    chk("clr_wait2_data", data, 8'h01);
    chk("clr_wait2_ack", {ack1, ack0}, 0);
    step();
    chk("clr_idle_busy", busy, 0);
    chk("clr_idle_data", data, 8'h41);
    step();
    chk("clr_req0_setup_ack", ack0, 0);
    step();
    chk("clr_req0_ack0", ack0, 1);
    chk("clr_req0_en", en, 1);
    req0 = 1'b0;
    step();

    // reset during the strobe of a data write
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'h5A;
    step(); step();
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("abort_en", en, 0);
    chk("abort_data", data, 8'h00);
    chk("abort_ack", {ack1, ack0}, 0);
    chk("abort_busy", busy, 1);
    step();
    chk("abort_hold_ack", {ack1, ack0}, 0);
    chk("abort_hold_done", init_done, 0);
    rst = 1'b0;
    run_init();

    // both requesters held: grants alternate 0,1,0,1 with a 3-cycle period
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'hA0;
    req1 = 1'b1; rs1 = 1'b1; byte1 = 8'hB0;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("rr_ack0_c%0d", c), ack0, (c == 3 || c == 9));
      chk($sformatf("rr_ack1_c%0d", c), ack1, (c == 6 || c == 12));
      if (c % 3 == 0) chk($sformatf("rr_data_c%0d", c), data, (c % 6 == 0) ? 8'hB0 : 8'hA0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sched.md
LCD_BUS_SCHED -- requirements
Module: lcd_bus_sched

Interface
REQ-001 Parameter CLR_WAIT, default 2: number of extra idle cycles after a clear (0x01) or home (0x02) command.
REQ-002 Parameter INIT_EN, default 1: when 1, the power-on init sequence runs after reset; when 0, the block enters IDLE directly.
REQ-003 clk_LCD  in  1  1 kHz LCD clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0, req1  in  1 each  write request from requester 0 (line-1 text) and requester 1 (line-2 progress).
REQ-006 rs0, rs1  in  1 each  register select for that request (0 = command, 1 = data).
REQ-007 byte0, byte1  in  8 each  byte to write for that request.
REQ-008 ack0, ack1  out  1 each  one-cycle pulse signalling the byte was strobed.
REQ-009 en, RS, RW  out  1 each  LCD enable, register select, read/write (RW is constant 0).
REQ-010 data  out  8  LCD data bus.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 init_done  out  1  sticky high from the first entry into IDLE after reset.

Function
REQ-013 The FSM shall have the states INIT_SETUP, INIT_STROBE, IDLE, SETUP, STROBE and WAIT.
REQ-014 The init sequence shall send, as commands (RS=0), 0x38, 0x0C, 0x06, 0x01 in that order, indexed by a 2-bit counter.
REQ-015 Each init byte shall take two cycles: INIT_SETUP drives data and RS with en=0; INIT_STROBE holds data and RS with en=1.
REQ-016 After the 0x01 init strobe, the block shall enter WAIT for CLR_WAIT cycles, then go to IDLE.
REQ-017 In IDLE with at least one request high, the block shall grant one requester, latch its rs/byte into RS/data, and go to SETUP.
REQ-018 Arbitration shall be 2-way round-robin.
  - A single requester is always granted.
  - On a tie, the requester not granted last wins.
  - The last-grant register updates on each grant.
REQ-019 SETUP: en=0, data and RS stable. STROBE: en=1, and the ack of the granted requester pulses high for exactly this cycle.
REQ-020 After STROBE, if the latched RS=0 and the byte is 0x01 or 0x02, go to WAIT for CLR_WAIT cycles, then IDLE; otherwise go to IDLE.
REQ-021 Latency from a request sampled in IDLE to its ack is 2 cycles; the minimum period for back-to-back writes is 3 cycles.
REQ-022 Requests shall be ignored outside IDLE.
REQ-023 A request dropped after its grant still completes and is still acked.
REQ-024 Requesters hold req/rs/byte until ack; a requester may present its next byte in the cycle after ack.
REQ-025 With CLR_WAIT=0, WAIT shall be skipped and the block goes straight to IDLE.
REQ-026 data and RS shall hold their last values in WAIT and IDLE.
REQ-027 en shall be registered and high only in INIT_STROBE or STROBE.
REQ-028 At most one ack shall be high per cycle, and never during init.

Reset
REQ-029 While rst is high, the outputs shall be: en=0, RS=0, RW=0, data=0x00, ack0=ack1=0, busy=1, init_done=0.
REQ-030 Reset shall clear the init index, the wait counter and the grant latch, and set the last grant to requester 1 so that requester 0 wins the first tie.
REQ-031 After reset, the state shall be INIT_SETUP (INIT_EN=1) or IDLE (INIT_EN=0).
REQ-032 Reset asserted mid-transfer shall abort it with no ack; the init sequence then restarts from 0x38.

Structure
REQ-033 The shared package shall hold:
  - LCD command constants: FUNC_SET 0x38, DISP_ON 0x0C, ENTRY_MODE 0x06, CLEAR 0x01, HOME 0x02.
  - The FSM state encoding.
REQ-034 The round-robin grant logic shall be a sub-module, lcd_rr_arb (inputs: req vector, last-grant; output: one-hot grant).

Verification
REQ-035 Reset release with no requests -> data goes 38, 0C, 06, 01 with en high on cycles 2, 4, 6, 8; init_done rises on cycle 11 (CLR_WAIT=2).
REQ-036 After init, req0 only with rs0=1, byte0=0x53 -> SETUP then STROBE: data=0x53, RS=1, en=1, ack0=1 two cycles after the sample; ack1 stays 0.
REQ-037 req0 and req1 held high continuously -> grant order 0, 1, 0, 1, with an ack every 3 cycles.
REQ-038 req1 with rs1=0, byte1=0x01 -> ack1 on STROBE, then busy high for 2 WAIT cycles; a req0 raised during WAIT is granted only on the next IDLE.
REQ-039 rst pulsed during the STROBE of a data write -> no ack; outputs at their reset values; the sequence restarts at 0x38.
REQ-040 INIT_EN=0 -> IDLE and init_done=1 one cycle after reset release; no init bytes are strobed.
